// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit pipeline: opcodes, field positions, NOP,
// and per-opcode register usage (writes rd / reads rs1 / reads rs2).
// Pure combinational helpers; no latency, no flow control.
package cpu_isa_pkg;

    localparam int ISA_W = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NAND = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_LI   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;

    localparam logic [ISA_W-1:0] NOP = 16'h0000;

    typedef logic [2:0] reg_idx_t;

    function automatic logic [3:0] op_of(input logic [ISA_W-1:0] ins);
        return ins[OP_HI:OP_LO];
    endfunction

    function automatic reg_idx_t rd_of(input logic [ISA_W-1:0] ins);
        return ins[RD_HI:RD_LO];
    endfunction

    function automatic reg_idx_t rs1_of(input logic [ISA_W-1:0] ins);
        return ins[RS1_HI:RS1_LO];
    endfunction

    function automatic reg_idx_t rs2_of(input logic [ISA_W-1:0] ins);
        return ins[RS2_HI:RS2_LO];
    endfunction

    function automatic logic writes_rd(input logic [ISA_W-1:0] ins);
        case (op_of(ins))
            OP_ADD, OP_SUB, OP_NAND, OP_LW, OP_LI: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [ISA_W-1:0] ins);
        case (op_of(ins))
            OP_ADD, OP_SUB, OP_NAND, OP_LW, OP_SW, OP_BEQ: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [ISA_W-1:0] ins);
        case (op_of(ins))
            OP_ADD, OP_SUB, OP_NAND, OP_SW, OP_BEQ: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Register file: two async read ports, one sync write port, r0 hardwired to zero.
// Latency: reads 0 cycles (same-cycle write data bypassed), write commits on the edge.
// Backpressure: none; writes always accepted.
module regfile_8x16 #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_dat,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_dat,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    // Writeback data wins over the stored value so decode never needs a WB interlock.
    always_comb begin
        ra_dat = regs[ra_addr];
        if (ra_addr == '0)
            ra_dat = '0;
        else if (wr_en && wr_addr == ra_addr)
            ra_dat = wr_dat;
    end

    always_comb begin
        rb_dat = regs[rb_addr];
        if (rb_addr == '0)
            rb_dat = '0;
        else if (wr_en && wr_addr == rb_addr)
            rb_dat = wr_dat;
    end

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode stage: IF/ID register, register file read, RAW interlock against EX/MEM.
// Latency: insout/rega/regb are the IF/ID register plus combinational read (0 added).
// Backpressure: dhazard holds IF/ID and fetch; STALL_COUNTER_EN enables the stall counter.
module decode_hazard_stage
    import cpu_isa_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int CNT_W  = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ins_in,
    input  logic              ins_valid,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] ex_ins,
    input  logic [DATA_W-1:0] mem_ins,
    output logic [DATA_W-1:0] insout,
    output logic [DATA_W-1:0] rega,
    output logic [DATA_W-1:0] regb,
    output logic              dhazard,
    output logic              fetch_stall,
    output logic [CNT_W-1:0]  stall_count
);

    logic [DATA_W-1:0] ifid;
    logic              raw_hit;

    function automatic logic conflict(input reg_idx_t src, input logic [DATA_W-1:0] prod);
        return (src != '0) && writes_rd(prod) && (rd_of(prod) == src);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ifid <= NOP;
        else if (flush)
            ifid <= NOP;
        else if (!dhazard)
            ifid <= ins_valid ? ins_in : NOP;
    end

    regfile_8x16 #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (rs1_of(ifid)),
        .ra_dat  (rega),
        .rb_addr (rs2_of(ifid)),
        .rb_dat  (regb),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_dat  (wb_data)
    );

    // Writeback is not checked: the regfile bypass already covers it.
    always_comb begin
        raw_hit = 1'b0;
        if (uses_rs1(ifid))
            raw_hit = raw_hit | conflict(rs1_of(ifid), ex_ins) | conflict(rs1_of(ifid), mem_ins);
        if (uses_rs2(ifid))
            raw_hit = raw_hit | conflict(rs2_of(ifid), ex_ins) | conflict(rs2_of(ifid), mem_ins);
    end

    assign dhazard     = raw_hit & ~flush;
    assign fetch_stall = dhazard;
    assign insout      = ifid;

`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (dhazard && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule
